// File: rtl/seriale_pkg.sv
// +-------------------------------------------------------------------------+
// | seriale_pkg: state encoding and line constants shared by the serial     |
// | transmitter and receiver.                                               |
// | Revision: 1.0                                                           |
// +-------------------------------------------------------------------------+
`default_nettype none

package seriale_pkg;

  typedef enum logic [2:0] {
    S0     = 3'd0,
    Wstart = 3'd1,
    Wbit   = 3'd2,
    Wpar   = 3'd3,
    Wstop  = 3'd4,
    Wack   = 3'd5
  } star_t;

  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;
  localparam int   DATA_BITS   = 8;

endpackage

`default_nettype wire

// File: rtl/trasmettitore_seriale_bit_timer.sv
// +-------------------------------------------------------------------------+
// | bit_timer: loadable down-counter with terminal-count flag (count == 0). |
// | Revision: 1.0                                                           |
// +-------------------------------------------------------------------------+
`default_nettype none

module bit_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic             tc_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Free-running between loads; wrap-around past zero is never observed.
  always_comb begin
    count_d = count_q - WIDTH'(1);
    if (load_i) count_d = load_val_i;
  end

  always_ff @(posedge clock) begin
    count_q <= count_d;
  end

  assign tc_o = (count_q == '0);

endmodule

`default_nettype wire

// File: rtl/trasmettitore_seriale.sv
// +-------------------------------------------------------------------------+
// | trasmettitore_seriale: async serial transmitter, start/8 data LSB-first |
// | /stop, with a dav_/rfd four-phase handshake on the parallel side.       |
// | Optional even parity bit: define TRASMETTITORE_PARITY_EN.               |
// | Revision: 1.0                                                           |
// +-------------------------------------------------------------------------+
`default_nettype none

module trasmettitore_seriale
  import seriale_pkg::*;
#(
  parameter int BIT_TICKS = 16,
  parameter int STOP_BITS = 1
) (
  input  logic       clock,
  input  logic       reset_,
  input  logic       dav_,
  input  logic [7:0] byte_i,
  output logic       rfd,
  output logic       txd
);

  localparam int TW = $clog2(BIT_TICKS);
  localparam int SW = $clog2(2 * BIT_TICKS);
  localparam logic [TW-1:0] TICK_RELOAD = TW'(BIT_TICKS - 1);
  localparam logic [SW-1:0] STOP_RELOAD = SW'(STOP_BITS * BIT_TICKS - 1);

  star_t      state_q, state_d;
  logic [7:0] buf_q, buf_d;
  logic [3:0] count_q, count_d;
  logic       txd_q, txd_d;
  logic       rfd_q, rfd_d;
`ifdef TRASMETTITORE_PARITY_EN
  logic       par_q, par_d;
`endif

  logic tick_load, tick_tc;
  logic stop_load, stop_tc;

  bit_timer #(.WIDTH(TW)) u_tick_timer (
    .clock      (clock),
    .load_i     (tick_load),
    .load_val_i (TICK_RELOAD),
    .tc_o       (tick_tc)
  );

  bit_timer #(.WIDTH(SW)) u_stop_timer (
    .clock      (clock),
    .load_i     (stop_load),
    .load_val_i (STOP_RELOAD),
    .tc_o       (stop_tc)
  );

  always_comb begin
    state_d   = state_q;
    buf_d     = buf_q;
    count_d   = count_q;
    txd_d     = txd_q;
    rfd_d     = rfd_q;
`ifdef TRASMETTITORE_PARITY_EN
    par_d     = par_q;
`endif
    tick_load = 1'b0;
    stop_load = 1'b0;

    case (state_q)
      S0: begin
        txd_d = IDLE_LEVEL;
        rfd_d = 1'b1;
        if (!dav_) begin
          buf_d     = byte_i;
          rfd_d     = 1'b0;
          txd_d     = START_LEVEL;
          tick_load = 1'b1;
          count_d   = 4'(DATA_BITS);
`ifdef TRASMETTITORE_PARITY_EN
          par_d     = ^byte_i;
`endif
          state_d   = Wstart;
        end
      end
      Wstart: begin
        if (tick_tc) begin
          txd_d     = buf_q[0];
          buf_d     = {1'b0, buf_q[7:1]};
          tick_load = 1'b1;
          state_d   = Wbit;
        end
      end
      Wbit: begin
        if (tick_tc) begin
          count_d = count_q - 4'd1;
          // count_q==1 means the bit just finished was bit 7.
          if (count_q == 4'd1) begin
`ifdef TRASMETTITORE_PARITY_EN
            txd_d     = par_q;
            tick_load = 1'b1;
            state_d   = Wpar;
`else
            txd_d     = IDLE_LEVEL;
            stop_load = 1'b1;
            state_d   = Wstop;
`endif
          end else begin
            txd_d     = buf_q[0];
            buf_d     = {1'b0, buf_q[7:1]};
            tick_load = 1'b1;
          end
        end
      end
`ifdef TRASMETTITORE_PARITY_EN
      Wpar: begin
        if (tick_tc) begin
          txd_d     = IDLE_LEVEL;
          stop_load = 1'b1;
          state_d   = Wstop;
        end
      end
`endif
      Wstop: begin
        txd_d = IDLE_LEVEL;
        if (stop_tc) begin
          if (dav_) begin
            rfd_d   = 1'b1;
            state_d = S0;
          end else begin
            state_d = Wack;
          end
        end
      end
      Wack: begin
        txd_d = IDLE_LEVEL;
        if (dav_) begin
          rfd_d   = 1'b1;
          state_d = S0;
        end
      end
      default: begin
        txd_d   = IDLE_LEVEL;
        rfd_d   = 1'b1;
        state_d = S0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset_) begin
      state_q <= S0;
      txd_q   <= IDLE_LEVEL;
      rfd_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      txd_q   <= txd_d;
      rfd_q   <= rfd_d;
    end
  end

  // Datapath registers need no reset: they are always loaded before use.
  always_ff @(posedge clock) begin
    buf_q   <= buf_d;
    count_q <= count_d;
`ifdef TRASMETTITORE_PARITY_EN
    par_q   <= par_d;
`endif
  end

  assign txd = txd_q;
  assign rfd = rfd_q;

endmodule

`default_nettype wire
